generador_mdio: RTL and testbench
=================================

Name: generador_mdio

Overview:
MDIO management-side controller (STA). It sits directly upstream of receptorMDIO and generates MDC, MDIO_OUT and MDIO_OE from a 32-bit transaction word. For write frames it serializes all 32 bits. For read frames it sends the 14-bit header, releases the line for TA, then samples 16 data bits on MDIO_IN and presents them on RD_DATA.

Parameters:
PRE_LEN, 0, number of preamble '1' bits driven with MDIO_OE=1 before ST (0..32)

Ports:
CLK  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
MDIO_START  input  1  transaction request, sampled on CLK rising edge
T_DATA  input  32  frame word, transmitted MSB first: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data
MDIO_IN  input  1  serial data from PHY (valid during read data phase)
MDC  output  1  management clock = CLK/2, free-running
MDIO_OUT  output  1  serial data to PHY
MDIO_OE  output  1  1 while controller drives MDIO_OUT
RD_DATA  output  16  data captured in last read frame
DATA_RDY  output  1  one-CLK pulse when RD_DATA is updated

Behaviour:
- Reset (sync, takes effect at next CLK edge): MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, state=IDLE, bit counter=0. A reset mid-frame aborts the frame with no DATA_RDY.
- MDC toggles on every CLK edge when not in reset.
  - "Falling edge" = CLK edge where MDC goes 1->0.
  - "Rising edge" = CLK edge where MDC goes 0->1.
- MDIO_OUT and MDIO_OE change only on falling edges. MDIO_IN is sampled only on rising edges.
- One bit period = 2 CLK cycles.
- States:
  - IDLE: MDIO_OE=0, MDIO_OUT=0. When MDIO_START=1 and T_DATA[29:28] is 01 (write) or 10 (read), latch T_DATA and go to PRE, or to FRAME if PRE_LEN=0. Any other OP value is ignored and the block stays in IDLE.
  - PRE: at each falling edge drive MDIO_OUT=1, MDIO_OE=1, for PRE_LEN bit periods, then go to FRAME.
  - FRAME: counter 0..31; bit n = latched T_DATA[31-n], driven at the first falling edge after the request is latched.
    - Write: MDIO_OE=1 for bits 0..31.
    - Read: MDIO_OE=1 for bits 0..13. From bit 14 onward MDIO_OE=0 and MDIO_OUT=0.
    - For read bits 16..31, MDIO_IN is shifted MSB-first into an internal shift register on the rising edge inside that bit period.
  - DONE: entered at the falling edge ending bit 31. MDIO_OE=0.
    - Read: RD_DATA <= shift register and DATA_RDY=1, both on the same edge, for exactly one CLK.
    - Write: RD_DATA is unchanged and DATA_RDY stays 0.
    - Return to IDLE on the next CLK.
- Latency: START at edge k -> first frame bit (or preamble) on MDIO_OUT at edge k+1 or k+2, whichever is the next falling edge.
  - Write frame length (PRE_LEN=0): 64 CLK from first bit to MDIO_OE=0.
  - Read frame: DATA_RDY 64 CLK after the first bit.
- MDIO_START while not in IDLE is ignored; there is no queuing. A START asserted in the same cycle DONE returns to IDLE is also ignored.
- T_DATA changes after latching do not affect the frame in progress.
- RD_DATA holds its value until the next completed read frame or reset.

Test Plan:
- Reset: hold reset 3 CLK mid-operation -> all outputs 0 on the next edge; MDC restarts from 0 after release.
- Write frame: PRE_LEN=0, T_DATA=32'h54515555, START pulse 1 CLK.
  - Required response: MDIO_OUT serializes 0101_0100_0101_0001_0101_0101_0101_0101, stable from each falling MDC edge.
  - MDIO_OE=1 for exactly 32 bit periods; DATA_RDY never asserts.
  - Cross-check with receptorMDIO: WR_STB, ADDR=5'b10100, WR_DATA=16'h5555.
- Read frame: T_DATA=32'h64500000, PHY model drives 16'hAAAA MSB-first on MDIO_IN.
  - Required response: MDIO_OE=1 for 14 bit periods then 0.
  - RD_DATA=16'hAAAA with a 1-CLK DATA_RDY pulse at bit 31 end.
- Invalid OP: T_DATA[29:28]=2'b11 with START -> MDIO_OE stays 0, state stays IDLE. A following valid write executes normally.
- Busy/abort:
  - START re-asserted at bit 10 of a write -> ignored, frame unchanged.
  - Reset at bit 20 of a read -> MDIO_OE=0, no DATA_RDY, RD_DATA=0.
- Preamble: PRE_LEN=32, write 32'h54515555 -> 32 '1' bits with MDIO_OE=1 precede ST; total 64 bit periods with MDIO_OE=1.

Source files
------------

// File: rtl/generador_mdio.sv
`default_nettype none
// ============================================================================
// Module   : generador_mdio
// Brief    : MDIO station-management frame generator (MDC = CLK/2, optional
//            preamble, 32-bit write frames, header + TA + 16-bit read frames).
// Revision : 1.0
// ============================================================================
module generador_mdio #(
  parameter int PRE_LEN = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] c_pre_last  = 6'(PRE_LEN - 1);
  localparam logic [5:0] c_frame_end = 6'd32;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_frame;
  logic        r_is_read;
  logic [15:0] r_shift;
  logic        r_mdc;
  logic        r_out;
  logic        r_oe;
  logic [15:0] r_rd_data;
  logic        r_rdy;

  logic w_start_ok;
  logic w_fall;
  logic w_drive;

  assign w_start_ok = MDIO_START && (T_DATA[29:28] == 2'b01 || T_DATA[29:28] == 2'b10);
  // MDC is about to go 1->0 on this edge
  assign w_fall     = r_mdc;
  // read frames release the line from the TA field onward
  assign w_drive    = !r_is_read || (r_cnt < 6'd14);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_frame   <= 32'h0;
      r_is_read <= 1'b0;
      r_shift   <= 16'h0;
      r_mdc     <= 1'b0;
      r_out     <= 1'b0;
      r_oe      <= 1'b0;
      r_rd_data <= 16'h0;
      r_rdy     <= 1'b0;
    end else begin
      r_mdc <= ~r_mdc;
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out <= 1'b0;
          r_oe  <= 1'b0;
          if (w_start_ok) begin
            r_frame   <= T_DATA;
            r_is_read <= (T_DATA[29:28] == 2'b10);
            r_cnt     <= 6'd0;
            r_state   <= (PRE_LEN == 0) ? S_FRAME : S_PRE;
          end
        end
        S_PRE: begin
          if (w_fall) begin
            r_out <= 1'b1;
            r_oe  <= 1'b1;
            if (r_cnt == c_pre_last) begin
              r_cnt   <= 6'd0;
              r_state <= S_FRAME;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        S_FRAME: begin
          if (w_fall) begin
            if (r_cnt == c_frame_end) begin
              r_out   <= 1'b0;
              r_oe    <= 1'b0;
              r_state <= S_DONE;
              if (r_is_read) begin
                r_rd_data <= r_shift;
                r_rdy     <= 1'b1;
              end
            end else begin
              r_out   <= w_drive & r_frame[31];
              r_oe    <= w_drive;
              r_frame <= {r_frame[30:0], 1'b0};
              r_cnt   <= r_cnt + 6'd1;
            end
          end else if (r_is_read && r_cnt >= 6'd17) begin
            // r_cnt is one past the bit being transferred: bits 16..31
            r_shift <= {r_shift[14:0], MDIO_IN};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MDC      = r_mdc;
  assign MDIO_OUT = r_out;
  assign MDIO_OE  = r_oe;
  assign RD_DATA  = r_rd_data;
  assign DATA_RDY = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_generador_mdio.sv
`default_nettype none
// Testbench for generador_mdio: two instances (no preamble / 32-bit preamble)
// compared edge by edge against a frame-list reference model.
module tb_generador_mdio;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        MDIO_START = 1'b0;
  logic [31:0] T_DATA = 32'h0;
  logic        mdio_in0 = 1'b0;
  logic        mdio_in1 = 1'b0;

  logic        mdc0, out0, oe0, rdy0;
  logic        mdc1, out1, oe1, rdy1;
  logic [15:0] rd0, rd1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  generador_mdio #(.PRE_LEN(0)) dut0 (
    .CLK(CLK), .reset(reset), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
    .MDIO_IN(mdio_in0), .MDC(mdc0), .MDIO_OUT(out0), .MDIO_OE(oe0),
    .RD_DATA(rd0), .DATA_RDY(rdy0)
  );

  generador_mdio #(.PRE_LEN(32)) dut1 (
    .CLK(CLK), .reset(reset), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
    .MDIO_IN(mdio_in1), .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1),
    .RD_DATA(rd1), .DATA_RDY(rdy1)
  );

  // Reference model: each accepted request becomes a list of per-bit-period
  // {out,oe} pairs that is played out one entry per falling MDC edge.
  int          m_pre [2] = '{0, 32};
  logic        m_mdc [2];
  logic        m_out [2];
  logic        m_oe  [2];
  logic        m_rdy [2];
  logic        m_busy[2];
  logic        m_done[2];
  logic        m_read[2];
  logic [15:0] m_rd  [2];
  logic [1:0]  m_seq [2][64];
  int          m_len [2];
  int          m_pos [2];
  logic [15:0] m_phy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mdc[i] = 0; m_out[i] = 0; m_oe[i] = 0; m_rdy[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_rd[i] = 16'h0; m_pos[i] = 0; m_len[i] = 0;
      end else begin
        logic fall, idle_before;
        fall        = m_mdc[i];
        m_mdc[i]    = !m_mdc[i];
        idle_before = !m_busy[i] && !m_done[i];
        m_rdy[i]    = 0;
        m_done[i]   = 0;
        if (m_busy[i] && fall) begin
          if (m_pos[i] < m_len[i]) begin
            {m_out[i], m_oe[i]} = m_seq[i][m_pos[i]];
            m_pos[i]++;
          end else begin
            m_out[i] = 0; m_oe[i] = 0; m_busy[i] = 0; m_done[i] = 1;
            if (m_read[i]) begin
              m_rd[i]  = m_phy;
              m_rdy[i] = 1;
            end
          end
        end
        if (idle_before && MDIO_START && (T_DATA[29:28] == 2'b01 || T_DATA[29:28] == 2'b10)) begin
          m_read[i] = (T_DATA[29:28] == 2'b10);
          m_len[i]  = m_pre[i] + 32;
          m_pos[i]  = 0;
          m_busy[i] = 1;
          for (int k = 0; k < m_pre[i]; k++) m_seq[i][k] = 2'b11;
          for (int n = 0; n < 32; n++) begin
            logic oe;
            oe = !m_read[i] || (n < 14);
            m_seq[i][m_pre[i] + n] = {oe & T_DATA[31-n], oe};
          end
        end
      end
    end
  endtask

  // PHY: valid read data only ahead of the rising edge of each data bit period
  function automatic logic phy_bit(input int i);
    int j;
    j = m_pos[i] - 1 - m_pre[i] - 16;
    if (m_busy[i] && m_read[i] && !m_mdc[i] && j >= 0 && j < 16)
      return m_phy[15-j];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("mdc0", {15'h0, mdc0}, {15'h0, m_mdc[0]});
    chk("out0", {15'h0, out0}, {15'h0, m_out[0]});
    chk("oe0",  {15'h0, oe0},  {15'h0, m_oe[0]});
    chk("rdy0", {15'h0, rdy0}, {15'h0, m_rdy[0]});
    chk("rd0",  rd0, m_rd[0]);
    chk("mdc1", {15'h0, mdc1}, {15'h0, m_mdc[1]});
    chk("out1", {15'h0, out1}, {15'h0, m_out[1]});
    chk("oe1",  {15'h0, oe1},  {15'h0, m_oe[1]});
    chk("rdy1", {15'h0, rdy1}, {15'h0, m_rdy[1]});
    chk("rd1",  rd1, m_rd[1]);
    mdio_in0 = phy_bit(0);
    mdio_in1 = phy_bit(1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy[0] || m_done[0] || m_busy[1] || m_done[1]) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    assert (n < budget) else begin
      n_errors++;
      $error("FAIL idle_timeout observed=%0d expected<%0d", n, budget);
    end
    step();
    step();
  endtask

  task automatic start_frame(input logic [31:0] word, input logic [15:0] phy);
    m_phy      = phy;
    T_DATA     = word;
    MDIO_START = 1'b1;
    step();
    MDIO_START = 1'b0;
    T_DATA     = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mdc[i] = 0; m_out[i] = 0; m_oe[i] = 0; m_rdy[i] = 0; m_busy[i] = 0;
      m_done[i] = 0; m_read[i] = 0; m_rd[i] = 16'h0; m_len[i] = 0; m_pos[i] = 0;
    end
    m_phy = 16'h0;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();

    // directed write, then read with PHY returning AAAA
    start_frame(32'h54515555, 16'h0000);
    wait_idle(400);
    start_frame(32'h64500000, 16'hAAAA);
    wait_idle(400);

    // invalid opcode ignored, then a valid write
    start_frame(32'h74515555, 16'h0000);
    repeat (6) step();
    start_frame(32'h54515555, 16'h0000);
    wait_idle(400);

    // second request mid-frame must be ignored
    start_frame(32'h54515555, 16'h0000);
    repeat (21) step();
    start_frame(32'h6A5A0000, 16'h1234);
    wait_idle(400);

    // reset in the middle of a read frame
    start_frame(32'h64500000, 16'h5A5A);
    repeat (41) step();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();

    // randomized frames with random MDC phase at request time
    for (int t = 0; t < 10; t++) begin
      logic [31:0] w;
      w = $urandom;
      w[29:28] = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) step();
      start_frame(w, 16'($urandom));
      wait_idle(400);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
